// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, FSM states and
// the alignment rule used to reject an access before it reaches the memory port.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Illegal size counts as misaligned so both error sources share one path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size_e'(size))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// plus load-data extraction with sign/zero extension.
module mem_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be_o    = '0;
    st_wdata_o = '0;
    case (size_e'(st_size_i))
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      SZ_WORD: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
      default: begin
        st_be_o    = '0;
        st_wdata_o = '0;
      end
    endcase
  end

  always_comb begin
    ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o  = ld_rdata_i;
    case (size_e'(ld_size_i))
      SZ_BYTE: ld_data_o = ld_unsigned_i ? {24'b0, ld_shifted[7:0]}
                                         : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_data_o = ld_unsigned_i ? {16'b0, ld_shifted[15:0]}
                                         : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory pipeline stage: issues multi-cycle valid/ready data-memory accesses,
// stalls the front of the pipe while one is outstanding, and registers M/W.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMER_W        = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic        ResultSrcM,
  input  logic [1:0]  SizeM,
  input  logic        LoadUnsignedM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        MemErrorW
);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                valid_q, valid_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic [1:0]          ld_size_q, ld_size_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                ld_uns_q, ld_uns_d;

  logic                regwrite_q, regwrite_d;
  logic                resultsrc_q, resultsrc_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         pc4_q, pc4_d;
  logic [31:0]         alu_q, alu_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                op, misaligned, issue, timeout, stall, err_now;
  logic [3:0]          st_be;
  logic [31:0]         st_wdata, ld_data, w_rdata;

  mem_lane_align u_align (
    .st_size_i     (SizeM),
    .st_off_i      (ALU_ResultM[1:0]),
    .st_data_i     (WriteDataM),
    .st_be_o       (st_be),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_rdata_i    (mem_rdata),
    .ld_data_o     (ld_data)
  );

  assign op         = MemReadM | MemWriteM;
  assign misaligned = is_misaligned(SizeM, ALU_ResultM[1:0]);
  assign issue      = (state_q == ST_IDLE) && op && !misaligned;
  assign timeout    = (state_q == ST_BUSY) && !mem_ready &&
                      (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign stall      = issue || ((state_q == ST_BUSY) && !mem_ready && !timeout);
  assign err_now    = ((state_q == ST_IDLE) && op && misaligned) || timeout;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    valid_d   = valid_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_uns_d  = ld_uns_q;
    w_rdata   = '0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d   = ST_BUSY;
          timer_d   = '0;
          valid_d   = 1'b1;
          we_d      = MemWriteM;
          addr_d    = {ALU_ResultM[31:2], 2'b00};
          wdata_d   = st_wdata;
          be_d      = st_be;
          ld_size_d = SizeM;
          ld_off_d  = ALU_ResultM[1:0];
          ld_uns_d  = LoadUnsignedM;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          w_rdata = we_q ? '0 : ld_data;
        end else if (timeout) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stalled cycles load a bubble into W: enables cleared, payload held.
  always_comb begin
    regwrite_d  = 1'b0;
    err_d       = 1'b0;
    resultsrc_d = resultsrc_q;
    rd_d        = rd_q;
    pc4_d       = pc4_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    if (!stall) begin
      regwrite_d  = RegWriteM && !err_now;
      err_d       = err_now;
      resultsrc_d = ResultSrcM;
      rd_d        = RD_M;
      pc4_d       = PCPlus4M;
      alu_d       = ALU_ResultM;
      rdata_d     = w_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      valid_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      ld_size_q   <= '0;
      ld_off_q    <= '0;
      ld_uns_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      resultsrc_q <= 1'b0;
      rd_q        <= '0;
      pc4_q       <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_uns_q    <= ld_uns_d;
      regwrite_q  <= regwrite_d;
      resultsrc_q <= resultsrc_d;
      rd_q        <= rd_d;
      pc4_q       <= pc4_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_valid   = valid_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_be      = be_q;
  assign StallM      = stall;
  assign RegWriteW   = regwrite_q;
  assign ResultSrcW  = resultsrc_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc4_q;
  assign ALU_ResultW = alu_q;
  assign ReadDataW   = rdata_q;
  assign MemErrorW   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: the driver predicts each W retirement
// from the access rules and queues it; a monitor pops on every non-stalled edge.
module tb_mem_access_stage;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM, LoadUnsignedM;
  logic [1:0]  SizeM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        StallM, RegWriteW, ResultSrcW, MemErrorW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(TO), .TIMER_W(7)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .SizeM(SizeM), .LoadUnsignedM(LoadUnsignedM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
    .MemErrorW(MemErrorW)
  );

  typedef struct {
    logic        rw;
    logic        rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } wexp_t;

  wexp_t q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules, written from the access-size arithmetic.
  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [31:0] a);
    int unsigned bytes;
    if (sz == 2'b11) return 1'b1;
    bytes = 1 << sz;
    return (a % bytes) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
    logic [7:0] m;
    m = ((8'd1 << (1 << sz)) - 8'd1) << off;
    return m[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return {24'b0, d[7:0]} * 32'h01010101;
    if (sz == 2'b01) return {16'b0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [1:0] off,
                                           input logic uns, input logic [31:0] r);
    int          bits;
    logic [31:0] v, mask;
    if (sz == 2'b10) return r;
    bits = 8 << sz;
    mask = (32'd1 << bits) - 32'd1;
    v = (r >> (8 * off)) & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Monitor: any edge taken with StallM low retires one instruction into W.
  initial begin
    logic  s;
    wexp_t e;
    forever begin
      @(negedge clk);
      #2 s = StallM;
      @(posedge clk);
      #1;
      if (mon_en && rst) begin
        if (s) begin
          chk("bubble_regwrite", {31'b0, RegWriteW}, 32'd0);
          chk("bubble_err", {31'b0, MemErrorW}, 32'd0);
        end else if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got W update expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("w_regwrite", {31'b0, RegWriteW}, {31'b0, e.rw});
          chk("w_resultsrc", {31'b0, ResultSrcW}, {31'b0, e.rs});
          chk("w_rd", {27'b0, RD_W}, {27'b0, e.rd});
          chk("w_pc4", PCPlus4W, e.pc);
          chk("w_alu", ALU_ResultW, e.alu);
          chk("w_memerr", {31'b0, MemErrorW}, {31'b0, e.err});
          if (e.chk_rd) chk("w_readdata", ReadDataW, e.rdata);
        end
      end
    end
  end

  task automatic drive_zero();
    RegWriteM = 0; MemWriteM = 0; MemReadM = 0; ResultSrcM = 0; SizeM = 0;
    LoadUnsignedM = 0; RD_M = 0; PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;
  endtask

  // One instruction in M; lat = BUSY cycle in which mem_ready is returned.
  task automatic run(input logic rw, input logic wr, input logic rdq, input logic rs,
                     input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                     input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                     input int lat, input logic [31:0] rdat, input bit do_reset);
    bit    op, mis, exp_stall;
    wexp_t e;
    @(negedge clk);
    RegWriteM = rw; MemWriteM = wr; MemReadM = rdq; ResultSrcM = rs; SizeM = sz;
    LoadUnsignedM = uns; RD_M = rd; PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
    mem_ready = 1'($urandom_range(1, 0));
    mem_rdata = $urandom;
    #1;
    op  = rdq || wr;
    mis = op && ref_misaligned(sz, alu);
    chk("valid_idle", {31'b0, mem_valid}, 32'd0);
    e = '{rw: rw && !mis, rs: rs, rd: rd, pc: pc, alu: alu, err: mis, chk_rd: 1'b0, rdata: '0};
    if (!op || mis) begin
      chk("stall_idle", {31'b0, StallM}, 32'd0);
      q.push_back(e);
      return;
    end
    chk("stall_issue", {31'b0, StallM}, 32'd1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      mem_ready = (k == lat);
      mem_rdata = (k == lat) ? rdat : $urandom;
      #1;
      chk("req_valid", {31'b0, mem_valid}, 32'd1);
      chk("req_addr", mem_addr, {alu[31:2], 2'b00});
      chk("req_we", {31'b0, mem_we}, {31'b0, wr});
      chk("req_be", {28'b0, mem_be}, {28'b0, ref_be(sz, alu[1:0])});
      if (wr) chk("req_wdata", mem_wdata, ref_wdata(sz, wd));
      if (do_reset && k == 3) begin
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_be", {28'b0, mem_be}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_regwrite", {31'b0, RegWriteW}, 32'd0);
        chk("rst_rd", {27'b0, RD_W}, 32'd0);
        chk("rst_alu", ALU_ResultW, 32'd0);
        chk("rst_pc4", PCPlus4W, 32'd0);
        chk("rst_rdata", ReadDataW, 32'd0);
        chk("rst_err", {31'b0, MemErrorW}, 32'd0);
        q.delete();
        drive_zero();
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        q.push_back('{rw: 1'b0, rs: 1'b0, rd: '0, pc: '0, alu: '0, err: 1'b0,
                      chk_rd: 1'b0, rdata: '0});
        return;
      end
      exp_stall = (k != lat) && (k != TO);
      chk("stall_busy", {31'b0, StallM}, {31'b0, exp_stall});
      if (!exp_stall) begin
        if (k != lat) begin
          e.rw = 1'b0;
          e.err = 1'b1;
        end else if (!wr) begin
          e.chk_rd = 1'b1;
          e.rdata = ref_load(sz, alu[1:0], uns, rdat);
        end
        q.push_back(e);
        return;
      end
    end
  endtask

  initial begin
    logic [1:0]  kind, sz;
    logic [31:0] a;
    rst = 1'b0;
    drive_zero();
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk("reset_valid", {31'b0, mem_valid}, 32'd0);
    chk("reset_we", {31'b0, mem_we}, 32'd0);
    chk("reset_addr", mem_addr, 32'd0);
    chk("reset_wdata", mem_wdata, 32'd0);
    chk("reset_regwrite", {31'b0, RegWriteW}, 32'd0);
    chk("reset_readdata", ReadDataW, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    q.push_back('{rw: 1'b0, rs: 1'b0, rd: '0, pc: '0, alu: '0, err: 1'b0, chk_rd: 1'b0, rdata: '0});

    run(1, 0, 0, 0, 2'b10, 0, 5'd5,  32'h4,   32'h1234, 32'h0,  0, 32'h0, 0);
    run(1, 0, 1, 1, 2'b10, 0, 5'd7,  32'h8,   32'h100,  32'h0,  3, 32'hDEADBEEF, 0);
    run(0, 1, 0, 0, 2'b00, 0, 5'd0,  32'hC,   32'h203,  32'hA5, 1, 32'h0, 0);
    run(1, 0, 1, 1, 2'b00, 0, 5'd9,  32'h10,  32'h203,  32'h0,  1, 32'h80FFFFFF, 0);
    run(1, 0, 1, 1, 2'b00, 1, 5'd9,  32'h14,  32'h203,  32'h0,  2, 32'h80FFFFFF, 0);
    run(1, 0, 1, 1, 2'b01, 0, 5'd3,  32'h18,  32'h101,  32'h0,  1, 32'h0, 0);
    run(1, 0, 0, 0, 2'b00, 0, 5'd4,  32'h1C,  32'h55,   32'h0,  0, 32'h0, 0);
    run(1, 0, 1, 1, 2'b10, 0, 5'd11, 32'h20,  32'h40,   32'h0,  1000, 32'h0, 0);
    run(1, 0, 1, 1, 2'b10, 0, 5'd12, 32'h24,  32'h44,   32'h0,  1, 32'h12345678, 0);
    run(1, 0, 1, 1, 2'b10, 0, 5'd13, 32'h28,  32'h48,   32'h0,  1000, 32'h0, 1);
    run(0, 1, 0, 0, 2'b10, 0, 5'd0,  32'h2C,  32'h300,  32'hCAFEF00D, 2, 32'h0, 0);
    run(1, 1, 1, 1, 2'b11, 0, 5'd14, 32'h30,  32'h300,  32'h1,  1, 32'h0, 0);

    for (int i = 0; i < 80; i++) begin
      kind = 2'($urandom_range(3, 0));
      sz   = 2'($urandom_range(3, 0));
      a    = $urandom;
      if ($urandom_range(2, 0) != 0 && sz != 2'b11)
        a = a & ~((32'd1 << sz) - 32'd1);
      run(1'($urandom_range(1, 0)), kind[1], kind[0], 1'($urandom_range(1, 0)), sz,
          1'($urandom_range(1, 0)), 5'($urandom_range(31, 0)), $urandom, a, $urandom,
          int'($urandom_range(4, 1)), $urandom, 0);
    end

    run(0, 0, 0, 0, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    drive_zero();
    q.push_back('{rw: 1'b0, rs: 1'b0, rd: '0, pc: '0, alu: '0, err: 1'b0, chk_rd: 1'b0, rdata: '0});
    @(negedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
